// File: rtl/ps2_matrix.sv
// ps2_matrix: PS/2 keyboard receiver feeding an 8x5 active-low key matrix.
// Optional PS2_COMBO_EN adds a combo register for multi-key shortcuts.
`default_nettype none

module ps2_matrix #(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       ps2Ck,
    input  logic       ps2D,
    input  logic [7:0] row,
    output logic [4:0] col,
    output logic [7:0] code,
    output logic       strobe
);

    localparam int FW = $clog2(FILTER) + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic [1:0]    r_ck_s, r_d_s;
    logic          r_ck_f;
    logic [FW-1:0] r_fcnt;
    logic [TW-1:0] r_tmr;
    state_t        r_state, w_state_nxt;
    logic [7:0]    r_sr, r_code;
    logic [2:0]    r_bcnt;
    logic          r_par, r_par_ok, r_strobe, r_ext, r_rel;
    logic [39:0]   r_key, w_matrix;
    logic          w_ck, w_d, w_flip, w_fall, w_tout, w_accept, w_hit;
    logic [5:0]    w_idx;
    logic [4:0]    w_col_n;

    assign w_ck   = r_ck_s[1];
    assign w_d    = r_d_s[1];
    assign w_flip = ce && (w_ck != r_ck_f) && (r_fcnt == FW'(FILTER - 1));
    assign w_fall = w_flip && !w_ck;
    assign w_tout = (r_state != S_IDLE) && ce && !w_fall && (r_tmr == TW'(TIMEOUT - 1));

    // Lines idle high, so sync and filter reset to 1 to avoid a phantom fall.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ck_s <= 2'b11;
            r_d_s  <= 2'b11;
            r_ck_f <= 1'b1;
            r_fcnt <= '0;
        end else begin
            r_ck_s <= {r_ck_s[0], ps2Ck};
            r_d_s  <= {r_d_s[0], ps2D};
            if (ce) begin
                if (w_ck == r_ck_f) begin
                    r_fcnt <= '0;
                end else if (w_flip) begin
                    r_ck_f <= w_ck;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + FW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        if (w_tout) begin
            w_state_nxt = S_IDLE;
        end else if (w_fall) begin
            case (r_state)
                S_IDLE:   if (!w_d) w_state_nxt = S_DATA;
                S_DATA:   if (r_bcnt == 3'd7) w_state_nxt = S_PARITY;
                S_PARITY: w_state_nxt = S_STOP;
                S_STOP: begin
                    w_state_nxt = S_IDLE;
                    w_accept    = w_d && r_par_ok;
                end
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sr     <= '0;
            r_bcnt   <= '0;
            r_par    <= 1'b0;
            r_par_ok <= 1'b0;
            r_tmr    <= '0;
        end else begin
            if (r_state == S_IDLE || w_fall) r_tmr <= '0;
            else if (ce)                     r_tmr <= w_tout ? '0 : r_tmr + TW'(1);
            if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        r_bcnt <= '0;
                        r_par  <= 1'b0;
                    end
                    S_DATA: begin
                        r_sr   <= {w_d, r_sr[7:1]};
                        r_par  <= r_par ^ w_d;
                        r_bcnt <= r_bcnt + 3'd1;
                    end
                    S_PARITY: r_par_ok <= r_par ^ w_d;
                    default:  ;
                endcase
            end
        end
    end

    // Scancode set 2 to matrix position row*5+column.
    always_comb begin
        w_hit = 1'b1;
        w_idx = '0;
        case (r_sr)
            8'h12: w_idx = 6'd0;  8'h1A: w_idx = 6'd1;  8'h22: w_idx = 6'd2;  8'h21: w_idx = 6'd3;
            8'h2A: w_idx = 6'd4;  8'h1C: w_idx = 6'd5;  8'h1B: w_idx = 6'd6;  8'h23: w_idx = 6'd7;
            8'h2B: w_idx = 6'd8;  8'h34: w_idx = 6'd9;  8'h15: w_idx = 6'd10; 8'h1D: w_idx = 6'd11;
            8'h24: w_idx = 6'd12; 8'h2D: w_idx = 6'd13; 8'h2C: w_idx = 6'd14; 8'h16: w_idx = 6'd15;
            8'h1E: w_idx = 6'd16; 8'h26: w_idx = 6'd17; 8'h25: w_idx = 6'd18; 8'h2E: w_idx = 6'd19;
            8'h45: w_idx = 6'd20; 8'h46: w_idx = 6'd21; 8'h3E: w_idx = 6'd22; 8'h3D: w_idx = 6'd23;
            8'h36: w_idx = 6'd24; 8'h4D: w_idx = 6'd25; 8'h44: w_idx = 6'd26; 8'h43: w_idx = 6'd27;
            8'h3C: w_idx = 6'd28; 8'h35: w_idx = 6'd29; 8'h5A: w_idx = 6'd30; 8'h4B: w_idx = 6'd31;
            8'h42: w_idx = 6'd32; 8'h3B: w_idx = 6'd33; 8'h33: w_idx = 6'd34; 8'h29: w_idx = 6'd35;
            8'h59: w_idx = 6'd36; 8'h3A: w_idx = 6'd37; 8'h31: w_idx = 6'd38; 8'h32: w_idx = 6'd39;
            default: w_hit = 1'b0;
        endcase
    end

`ifdef PS2_COMBO_EN
    logic [39:0] r_combo, w_cmask;
    logic [5:0]  w_cidx;
    logic        w_chit;

    // Every combo is CAPS SHIFT (index 0) plus one other key.
    always_comb begin
        w_chit = 1'b1;
        w_cidx = '0;
        case (r_sr)
            8'h66:   w_cidx = 6'd20;
            8'h76:   w_cidx = 6'd35;
            8'h6B:   begin w_cidx = 6'd19; w_chit = r_ext; end
            8'h74:   begin w_cidx = 6'd22; w_chit = r_ext; end
            8'h72:   begin w_cidx = 6'd24; w_chit = r_ext; end
            8'h75:   begin w_cidx = 6'd23; w_chit = r_ext; end
            default: w_chit = 1'b0;
        endcase
        w_cmask = 40'd1 | (40'd1 << w_cidx);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_combo <= '0;
        end else if (w_accept && r_sr != 8'hE0 && r_sr != 8'hF0 && w_chit) begin
            r_combo <= r_rel ? (r_combo & ~w_cmask) : (r_combo | w_cmask);
        end
    end

    assign w_matrix = r_key | r_combo;
`else
    logic w_unused_ext;
    assign w_unused_ext = r_ext;
    assign w_matrix     = r_key;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_code   <= '0;
            r_strobe <= 1'b0;
            r_ext    <= 1'b0;
            r_rel    <= 1'b0;
            r_key    <= '0;
        end else begin
            r_strobe <= w_accept;
            if (w_accept) begin
                r_code <= r_sr;
                if (r_sr == 8'hE0) begin
                    r_ext <= 1'b1;
                end else if (r_sr == 8'hF0) begin
                    r_rel <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_rel <= 1'b0;
                    if (w_hit) r_key[w_idx] <= !r_rel;
                end
            end
        end
    end

    always_comb begin
        w_col_n = '0;
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 5; k++) begin
                if (!row[r] && w_matrix[r*5+k]) w_col_n[k] = 1'b1;
            end
        end
    end

    assign col    = ~w_col_n;
    assign code   = r_code;
    assign strobe = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_ps2_matrix.sv
// tb_ps2_matrix: frame-level stimulus with a scoreboard on strobe/code
// and a table of key sequences with expected column readings.
`default_nettype none

module tb_ps2_matrix;

    localparam int HALF = 24;

`ifdef PS2_COMBO_EN
    localparam logic [4:0] C_R0 = 5'h1E, C_R3 = 5'h0F, C_R4 = 5'h1E;
`else
    localparam logic [4:0] C_R0 = 5'h1F, C_R3 = 5'h1F, C_R4 = 5'h1F;
`endif

    logic       clock = 1'b0, reset = 1'b0, ce = 1'b0, ps2Ck = 1'b1, ps2D = 1'b1;
    logic [7:0] row = 8'hFF;
    logic [4:0] col;
    logic [7:0] code;
    logic       strobe;

    int         tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] m_code = 8'h00;
    logic [7:0] sb_e;

    typedef struct {
        logic [31:0] bytes;
        int          n;
        logic [7:0]  row;
        logic [4:0]  col;
    } vec_t;

    localparam int NV = 17;
    vec_t vt[NV];

    ps2_matrix dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .ps2Ck (ps2Ck),
        .ps2D  (ps2D),
        .row   (row),
        .col   (col),
        .code  (code),
        .strobe(strobe)
    );

    always #5 clock = ~clock;

    initial forever begin
        @(negedge clock);
        ce = ~ce;
    end

    always @(negedge clock) begin
        if (strobe) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL strobe: unexpected strobe with code %h, none expected", code);
            end else begin
                sb_e = exp_q.pop_front();
                if (code !== sb_e) begin
                    fails++;
                    $display("FAIL scoreboard: code %h expected %h", code, sb_e);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2D = f[i];
            wait_clk(HALF);
            ps2Ck = 1'b0;
            wait_clk(HALF);
            ps2Ck = 1'b1;
        end
        ps2D = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        m_code = b;
        send_bits(b, 1'b0, 11);
        wait_clk(HALF);
    endtask

    task automatic check_col(input string name, input logic [7:0] r, input logic [4:0] exp);
        @(negedge clock);
        row = r;
        #1;
        check(name, {3'b000, col}, {3'b000, exp});
    endtask

    initial begin
        vt[0]  = '{32'h0000001C, 1, 8'hFD, 5'h1E};
        vt[1]  = '{32'h00001CF0, 2, 8'hFD, 5'h1F};
        vt[2]  = '{32'h00001A12, 2, 8'hFE, 5'h1C};
        vt[3]  = '{32'h00000000, 0, 8'h00, 5'h1C};
        vt[4]  = '{32'h00000000, 0, 8'hFF, 5'h1F};
        vt[5]  = '{32'h00001C1C, 2, 8'hFC, 5'h1C};
        vt[6]  = '{32'h1AF012F0, 4, 8'hFE, 5'h1F};
        vt[7]  = '{32'h1CF01CF0, 4, 8'hFD, 5'h1F};
        vt[8]  = '{32'h0000000E, 1, 8'h00, 5'h1F};
        vt[9]  = '{32'h00006BE0, 2, 8'hFE, C_R0};
        vt[10] = '{32'h00000000, 0, 8'hF7, C_R3};
        vt[11] = '{32'h006BF0E0, 3, 8'hFE, 5'h1F};
        vt[12] = '{32'h00000000, 0, 8'hF7, 5'h1F};
        vt[13] = '{32'h00006612, 2, 8'hEF, C_R4};
        vt[14] = '{32'h000066F0, 2, 8'hFE, 5'h1E};
        vt[15] = '{32'h00000000, 0, 8'hEF, 5'h1F};
        vt[16] = '{32'h000012F0, 2, 8'hFE, 5'h1F};

        wait_clk(5);
        reset = 1'b1;
        wait_clk(3);
        check("reset_code", code, 8'h00);
        check("reset_strobe", {7'd0, strobe}, 8'h00);
        check_col("reset_col", 8'h00, 5'h1F);

        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < vt[i].n; j++) send_byte(vt[i].bytes[8*j +: 8]);
            check_col($sformatf("vec%0d_col", i), vt[i].row, vt[i].col);
            check($sformatf("vec%0d_code", i), code, m_code);
        end

        // Bad parity: byte dropped silently.
        send_bits(8'h1C, 1'b1, 11);
        wait_clk(HALF);
        check_col("parity_col", 8'hFD, 5'h1F);
        check("parity_code", code, m_code);

        // Truncated frame recovered by the timeout.
        send_bits(8'h00, 1'b0, 5);
        wait_clk(9000);
        send_byte(8'h15);
        check_col("timeout_col", 8'hFB, 5'h1E);
        check("timeout_code", code, 8'h15);

        // Reset in the middle of a frame.
        send_bits(8'hFF, 1'b0, 4);
        reset = 1'b0;
        wait_clk(10);
        reset = 1'b1;
        wait_clk(3);
        check("rst2_code", code, 8'h00);
        check("rst2_strobe", {7'd0, strobe}, 8'h00);
        check_col("rst2_col", 8'h00, 5'h1F);
        m_code = 8'h00;
        send_byte(8'h29);
        check_col("rst2_spc_col", 8'h7F, 5'h1E);
        check("rst2_spc_code", code, 8'h29);

        wait_clk(HALF);
        check("scoreboard_empty", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1);
    end

endmodule

`default_nettype wire
